pmu_quota_regulator: RTL and testbench



---
 rtl/pmu_quota_regulator.sv | 180 ++++++++++++++++++
 tb/tb_pmu_quota_regulator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pmu_quota_regulator.sv
// Per-core quota regulator: period timer, checker soft-reset, stall handshake, overrun stats.
// Optional stall-cycle statistics output enabled by defining PMU_QUOTA_STALL_CYCLES_EN.
module pmu_quota_regulator #(
  parameter int PERIOD_WIDTH = 32,
  parameter int OVR_WIDTH    = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  input  logic                    intr_quota_i,
  input  logic                    stall_ack_i,
  input  logic                    clear_stats_i,
  output logic                    softrst_o,
  output logic                    stall_req_o,
  output logic [OVR_WIDTH-1:0]    overrun_cnt_o,
  output logic [PERIOD_WIDTH-1:0] period_cnt_o,
`ifdef PMU_QUOTA_STALL_CYCLES_EN
  output logic [PERIOD_WIDTH-1:0] stall_cycles_o,
`endif
  output logic [2:0]              state_o
);

  localparam int BW = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam logic [BW-1:0] BLANK_INIT = BW'(BLANK_CYCLES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REFILL   = 3'd1,
    RUN      = 3'd2,
    THROTTLE = 3'd3,
    RELEASE  = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [BW-1:0]           blank_q, blank_d;
  logic [OVR_WIDTH-1:0]    ovr_q, ovr_d;
  logic                    softrst_q, softrst_d;
  logic                    stall_q, stall_d;
  logic                    ovr_inc;
  logic [PERIOD_WIDTH-1:0] peff_m1;
  logic [PERIOD_WIDTH-1:0] cnt_inc;
  logic                    period_end;
  logic                    intr_valid;

  // Periods shorter than two cycles are floored to two, so the last cycle index is at least 1.
  assign peff_m1    = (period_i < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(1) : period_i - PERIOD_WIDTH'(1);
  assign cnt_inc    = cnt_q + PERIOD_WIDTH'(1);
  assign period_end = (cnt_q >= peff_m1);
  assign intr_valid = intr_quota_i && (blank_q == {BW{1'b0}});

  // Next-state, period timer and blanking window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blank_d = blank_q;
    ovr_inc = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable_i) state_d = REFILL;
        else          state_d = IDLE;
      end
      REFILL: begin
        state_d = RUN;
        cnt_d   = PERIOD_WIDTH'(1);
        blank_d = BLANK_INIT;
      end
      RUN: begin
        if (blank_q != {BW{1'b0}}) blank_d = blank_q - BW'(1);
        else                       blank_d = blank_q;
        if (!enable_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (period_end) begin
          // A coincident overrun is still recorded, but the refill wins over a stall.
          state_d = REFILL;
          cnt_d   = '0;
          ovr_inc = intr_valid;
        end else if (intr_valid) begin
          state_d = THROTTLE;
          cnt_d   = cnt_inc;
          ovr_inc = 1'b1;
        end else begin
          state_d = RUN;
          cnt_d   = cnt_inc;
        end
      end
      THROTTLE: begin
        if (!enable_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (period_end) begin
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RELEASE: begin
        // Refill only once the core no longer reports halted; the period stretches meanwhile.
        if (!stall_ack_i) begin
          state_d = REFILL;
          cnt_d   = '0;
        end else if (!enable_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = RELEASE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Saturating overrun counter; a clear beats a same-cycle increment.
  always_comb begin
    ovr_d = ovr_q;
    if (clear_stats_i)                        ovr_d = '0;
    else if (ovr_inc && (ovr_q != {OVR_WIDTH{1'b1}})) ovr_d = ovr_q + OVR_WIDTH'(1);
    else                                      ovr_d = ovr_q;
  end

  // Outputs are registered from the next state so they line up with state_o.
  always_comb begin
    softrst_d = (state_d == REFILL);
    stall_d   = (state_d == THROTTLE);
  end

`ifdef PMU_QUOTA_STALL_CYCLES_EN
  logic [PERIOD_WIDTH-1:0] stall_cyc_q, stall_cyc_d;

  // Count cycles in which the core is both asked to stall and reports halted.
  always_comb begin
    stall_cyc_d = stall_cyc_q;
    if (clear_stats_i) stall_cyc_d = '0;
    else if (stall_q && stall_ack_i && (stall_cyc_q != {PERIOD_WIDTH{1'b1}}))
      stall_cyc_d = stall_cyc_q + PERIOD_WIDTH'(1);
    else stall_cyc_d = stall_cyc_q;
  end

  // Stall-cycle statistics register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_cyc_q <= '0;
    else       stall_cyc_q <= stall_cyc_d;
  end

  assign stall_cycles_o = stall_cyc_q;
`endif

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      blank_q   <= '0;
      ovr_q     <= '0;
      softrst_q <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      blank_q   <= blank_d;
      ovr_q     <= ovr_d;
      softrst_q <= softrst_d;
      stall_q   <= stall_d;
    end
  end

  assign softrst_o     = softrst_q;
  assign stall_req_o   = stall_q;
  assign overrun_cnt_o = ovr_q;
  assign period_cnt_o  = cnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pmu_quota_regulator.sv
// Directed bench for pmu_quota_regulator with a period-position reference model checked every cycle.
module tb_pmu_quota_regulator;

  localparam int BLANK   = 2;
  localparam int OVR_W   = 2;
  localparam int OVR_MAX = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] period = 32'd10;
  logic        intr = 1'b0;
  logic        ack = 1'b0;
  logic        clr = 1'b0;
  logic        softrst, stall;
  logic [OVR_W-1:0] ovr;
  logic [31:0] pcnt;
  logic [2:0]  state;
`ifdef PMU_QUOTA_STALL_CYCLES_EN
  logic [31:0] stall_cycles;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;

  pmu_quota_regulator #(.PERIOD_WIDTH(32), .OVR_WIDTH(OVR_W), .BLANK_CYCLES(BLANK)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .period_i(period),
    .intr_quota_i(intr), .stall_ack_i(ack), .clear_stats_i(clr),
    .softrst_o(softrst), .stall_req_o(stall), .overrun_cnt_o(ovr),
    .period_cnt_o(pcnt),
`ifdef PMU_QUOTA_STALL_CYCLES_EN
    .stall_cycles_o(stall_cycles),
`endif
    .state_o(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: where we are in the period, and whether the core is running, throttled or awaiting release.
  typedef enum int {M_OFF, M_REFILL, M_RUN, M_THR, M_WAIT} mode_e;
  mode_e m_mode;
  int    m_pos;
  int    m_ovr;
  int    m_peff;
  bit    m_hit;
  bit    m_last;

  assign m_peff = (period < 32'd2) ? 2 : int'(period);
  assign m_last = (m_pos + 1 >= m_peff);
  // Quota signal only matters while running with enable, after the first BLANK run cycles of the period.
  assign m_hit  = en && intr && (m_mode == M_RUN) && (m_pos > BLANK);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= M_OFF; m_pos <= 0; m_ovr <= 0;
    end else begin
      if (clr) m_ovr <= 0;
      else if (m_hit && m_ovr < OVR_MAX) m_ovr <= m_ovr + 1;
      case (m_mode)
        M_OFF:    if (en) begin m_mode <= M_REFILL; m_pos <= 0; end
        M_REFILL: begin m_mode <= M_RUN; m_pos <= 1; end
        M_RUN: begin
          if (!en)        begin m_mode <= M_OFF;    m_pos <= 0; end
          else if (m_last) begin m_mode <= M_REFILL; m_pos <= 0; end
          else if (m_hit)  begin m_mode <= M_THR;    m_pos <= m_pos + 1; end
          else m_pos <= m_pos + 1;
        end
        M_THR: begin
          if (!en)         begin m_mode <= M_OFF; m_pos <= 0; end
          else if (m_last) m_mode <= M_WAIT;
          else m_pos <= m_pos + 1;
        end
        M_WAIT: begin
          if (!ack)     begin m_mode <= M_REFILL; m_pos <= 0; end
          else if (!en) begin m_mode <= M_OFF;    m_pos <= 0; end
        end
        default: begin m_mode <= M_OFF; m_pos <= 0; end
      endcase
    end
  end

  function automatic int code_of(input mode_e m);
    case (m)
      M_OFF:    return 0;
      M_REFILL: return 1;
      M_RUN:    return 2;
      M_THR:    return 3;
      M_WAIT:   return 4;
      default:  return 7;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("softrst", softrst, m_mode == M_REFILL);
      chk("stall_req", stall, m_mode == M_THR);
      chk("overrun_cnt", ovr, m_ovr);
      chk("period_cnt", pcnt, m_pos);
      chk("state", state, code_of(m_mode));
    end
  end

  task automatic wait_cnt(input int v, input int st, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pcnt == 32'(v) && state == 3'(st)) begin ok = 1'b1; break; end
    end
    chk(nm, ok, 1);
  endtask

  task automatic wait_state(input int st, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (state == 3'(st)) begin ok = 1'b1; break; end
    end
    chk(nm, ok, 1);
  endtask

  initial begin
    int pulses[$];
    bit saw_stall;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_softrst", softrst, 0);
    chk("rst_stall", stall, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_pcnt", pcnt, 0);
    rst = 1'b0;

    // Free-running periods with no quota events.
    en = 1'b1;
    saw_stall = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (softrst) pulses.push_back(cyc);
      if (stall) saw_stall = 1'b1;
    end
    chk("s1_npulses", pulses.size() >= 3, 1);
    if (pulses.size() >= 3) begin
      chk("s1_gap1", pulses[1] - pulses[0], 10);
      chk("s1_gap2", pulses[2] - pulses[1], 10);
    end
    chk("s1_no_stall", saw_stall, 0);
    chk("s1_ovr", ovr, 0);

    // Throttle and release handshake.
    wait_cnt(4, 2, "s2_sync");
    intr = 1'b1;
    @(negedge clk);
    chk("s2_stall", stall, 1);
    chk("s2_ovr", ovr, 1);
    intr = 1'b0; ack = 1'b1;
    wait_state(4, "s2_release");
    chk("s2_rel_pcnt", pcnt, 9);
    chk("s2_rel_stall", stall, 0);
    repeat (3) @(negedge clk);
    chk("s2_still_rel", state, 4);
    chk("s2_no_softrst", softrst, 0);
    ack = 1'b0;
    @(negedge clk);
    chk("s2_refill", softrst, 1);

    // Blanking window right after refill.
    intr = 1'b1;
    repeat (3) @(negedge clk);
    chk("s3_blank_stall", stall, 0);
    chk("s3_blank_ovr", ovr, 1);
    @(negedge clk);
    chk("s3_thr_stall", stall, 1);
    chk("s3_thr_ovr", ovr, 2);
    intr = 1'b0;
    wait_state(1, "s3_refill");

    // Overrun on the last cycle of a period.
    wait_cnt(9, 2, "s4_sync");
    intr = 1'b1;
    @(negedge clk);
    chk("s4_softrst", softrst, 1);
    chk("s4_stall", stall, 0);
    chk("s4_ovr", ovr, 3);
    intr = 1'b0;

    // Saturation, then clear coincident with an overrun.
    wait_cnt(5, 2, "s5_sync");
    intr = 1'b1;
    @(negedge clk);
    chk("s5_sat_stall", stall, 1);
    chk("s5_sat_ovr", ovr, 3);
    intr = 1'b0;
    wait_state(1, "s5_refill");
    wait_cnt(5, 2, "s5_sync2");
    intr = 1'b1; clr = 1'b1;
    @(negedge clk);
    chk("s5_clr_ovr", ovr, 0);
    chk("s5_clr_stall", stall, 1);
    intr = 1'b0; clr = 1'b0;

    // Period floor: zero behaves as two.
    period = 32'd0;
    wait_state(1, "s6_refill");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("s6_floor_softrst", softrst, (i % 2 == 1) ? 1 : 0);
    end

    // Asynchronous reset while throttled.
    period = 32'd10;
    wait_cnt(4, 2, "s7_sync");
    intr = 1'b1;
    @(negedge clk);
    chk("s7_stall", stall, 1);
    intr = 1'b0; ack = 1'b1;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("s7_ar_stall", stall, 0);
    chk("s7_ar_softrst", softrst, 0);
    chk("s7_ar_ovr", ovr, 0);
    chk("s7_ar_pcnt", pcnt, 0);
    chk("s7_ar_state", state, 0);
    @(negedge clk);
    rst = 1'b0; ack = 1'b0; en = 1'b0;
    repeat (3) @(negedge clk);
    chk("s7_idle", state, 0);

    // Disable from RUN.
    en = 1'b1;
    repeat (4) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("s8_disable_state", state, 0);
    chk("s8_disable_softrst", softrst, 0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
